memwb_stage_pipe: RTL and testbench
===================================

# memwb_stage_pipe

Parametrised write-back pipeline register for the phase-sequenced 16-bit core; successor to the fixed single-stage MEM/WB register. Captures MEM-stage results on the configured phase bit. Adds:
- configurable depth
- per-stage valid bits
- stall and flush
- registered write-back data selection
- forwarding-hit outputs for the operand-fetch stage

## Interface
Parameters:
- DATA_W, 16, width of ALU result and memory data
- REG_AW, 3, register-address width
- PHASE_W, 5, phasecounter width
- PHASE_BIT, 3, phasecounter bit that enables capture/advance
- DEPTH, 1, number of chained stages, legal 1..4

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- phasecounter  in  PHASE_W  one-hot phase vector
- stall  in  1  hold all stages
- flush  in  1  invalidate all stages
- in_valid  in  1  incoming instruction is real (0 = bubble)
- in_MemtoReg  in  1  select memory data for write-back
- in_RegWrite  in  1  instruction writes register file
- in_ALUResult  in  DATA_W  ALU result
- in_data  in  DATA_W  memory read data
- in_des  in  REG_AW  destination register
- src_a, src_b  in  REG_AW  operand addresses to check for forwarding
- stat_clear  in  1  synchronous clear of statistics counters
- out_valid  out  1  last stage holds a real instruction
- out_MemtoReg, out_RegWrite  out  1  last-stage control; out_RegWrite = valid & RegWrite
- out_ALUResult, out_data  out  DATA_W  last-stage payload
- out_wbdata  out  DATA_W  registered MemtoReg ? data : ALUResult
- out_des  out  REG_AW  last-stage destination
- fwd_hit_a, fwd_hit_b  out  1  a valid writing stage targets src_a / src_b
- fwd_data_a, fwd_data_b  out  DATA_W  wbdata of the matching stage, 0 if no hit
- stall_cnt, bubble_cnt  out  16  statistics counters

## Operation
- adv = phasecounter[PHASE_BIT] & ~stall. fl = phasecounter[PHASE_BIT] & flush.
- Priority per edge: reset > fl > adv > hold.
- fl: every stage valid ← 0; payload fields unchanged.
- adv: stage 0 ← inputs; stage k ← stage k-1. Stage 0 valid ← in_valid.
- Payload is loaded only when the incoming valid is 1; a bubble moves valid=0 and leaves the destination stage's payload unchanged.
- wbdata is computed at capture: stage 0 wbdata = in_MemtoReg ? in_data : in_ALUResult.
- Forwarding is combinational over stages with valid & RegWrite & des == src.
  - Youngest (stage 0) wins.
  - Register address 0 never hits.
  - With no hit: hit = 0, data = 0.
- Stall or phase bit low: all stages hold.
- A flush arriving outside the capture phase is ignored; the controller holds flush through the phase.

## Timing
- Reset: all valid, control, payload, wbdata, des = 0. Counters = 0. out_* and fwd_* = 0.
- Latency: an instruction appears at outputs after DEPTH advance edges.
- Forward outputs update in the same cycle as src_* changes; state updates one clock after capture.
- Reset asserted mid-stream: everything clears immediately, no partial stage retained.
- stall and flush asserted together in phase: flush wins, valids cleared.
- DEPTH=1: behaves as the legacy MEM/WB register plus valid/stall/flush.

## Configuration
- MEMWB_STAT_EN defined: counters are built.
  - stall_cnt increments on each phase-bit cycle with stall=1 and flush=0.
  - bubble_cnt increments on each adv with in_valid=0.
  - Both saturate at 16'hFFFF.
  - stat_clear zeros both; stat_clear has priority over increment.
- MEMWB_STAT_EN undefined: counter logic absent, stall_cnt and bubble_cnt tied to 0, stat_clear ignored.

## Test plan
- DEPTH=1: reset, then in_valid=1, RegWrite=1, ALUResult=16'h1234, des=3, MemtoReg=0 with phasecounter=5'b01000 → next edge out_valid=1, out_wbdata=16'h1234, out_RegWrite=1.
- DEPTH=3: three distinct instructions on consecutive advance phases → each appears after 3 advances. src_a=des of stage 1 and stage 0 both → fwd_data_a = stage 0 wbdata.
- Stall held for 4 phase cycles → outputs frozen; stall_cnt=4 with MEMWB_STAT_EN.
- Simultaneous stall=1, flush=1 in phase → all valids 0; out_RegWrite=0, fwd_hit_* = 0; payload unchanged.
- Flush outside the phase bit: phasecounter=5'b00001, flush=1 → no state change.
- Reset pulse mid-stream, including between edges → all outputs 0 asynchronously. 65540 bubbles → bubble_cnt=16'hFFFF; stat_clear → 0.

Source files
------------

// File: rtl/memwb_stage_pipe.sv
// memwb_stage_pipe: parametrised MEM/WB pipeline register for the
// phase-sequenced 16-bit core. DEPTH chained stages (legal 1..4), each with a
// valid bit, captured/advanced on phasecounter[PHASE_BIT]. Provides stall,
// flush, registered write-back data and forwarding-hit outputs.
// Optional statistics counters are built when MEMWB_STAT_EN is defined;
// otherwise stall_cnt/bubble_cnt are tied to zero and stat_clear is ignored.
module memwb_stage_pipe #(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int PHASE_W   = 5,
  parameter int PHASE_BIT = 3,
  parameter int DEPTH     = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phasecounter,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_MemtoReg,
  input  logic               in_RegWrite,
  input  logic [DATA_W-1:0]  in_ALUResult,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [REG_AW-1:0]  in_des,
  input  logic [REG_AW-1:0]  src_a,
  input  logic [REG_AW-1:0]  src_b,
  input  logic               stat_clear,
  output logic               out_valid,
  output logic               out_MemtoReg,
  output logic               out_RegWrite,
  output logic [DATA_W-1:0]  out_ALUResult,
  output logic [DATA_W-1:0]  out_data,
  output logic [DATA_W-1:0]  out_wbdata,
  output logic [REG_AW-1:0]  out_des,
  output logic               fwd_hit_a,
  output logic               fwd_hit_b,
  output logic [DATA_W-1:0]  fwd_data_a,
  output logic [DATA_W-1:0]  fwd_data_b,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        bubble_cnt
);

  // Stage 0 is the youngest, stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  memtoreg_r;
  logic [DEPTH-1:0]  regwrite_r;
  logic [DATA_W-1:0] alu_r    [DEPTH];
  logic [DATA_W-1:0] data_r   [DEPTH];
  logic [DATA_W-1:0] wbdata_r [DEPTH];
  logic [REG_AW-1:0] des_r    [DEPTH];

  logic phase_s;
  logic fl_s;
  logic adv_s;
  logic unused_pc_s;

  assign phase_s     = phasecounter[PHASE_BIT];
  // Flush outranks advance, so an advance only happens when no flush is pending.
  assign fl_s        = phase_s & flush;
  assign adv_s       = phase_s & ~stall & ~flush;
  assign unused_pc_s = ^phasecounter;

  // Stage registers: flush clears valids, advance shifts, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r    <= '0;
      memtoreg_r <= '0;
      regwrite_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        alu_r[k]    <= {DATA_W{1'b0}};
        data_r[k]   <= {DATA_W{1'b0}};
        wbdata_r[k] <= {DATA_W{1'b0}};
        des_r[k]    <= {REG_AW{1'b0}};
      end
    end else if (fl_s) begin
      valid_r <= '0;
    end else if (adv_s) begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        memtoreg_r[0] <= in_MemtoReg;
        regwrite_r[0] <= in_RegWrite;
        alu_r[0]      <= in_ALUResult;
        data_r[0]     <= in_data;
        wbdata_r[0]   <= in_MemtoReg ? in_data : in_ALUResult;
        des_r[0]      <= in_des;
      end else begin
        memtoreg_r[0] <= memtoreg_r[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        // A bubble leaves the receiving stage's payload untouched.
        if (valid_r[k-1]) begin
          memtoreg_r[k] <= memtoreg_r[k-1];
          regwrite_r[k] <= regwrite_r[k-1];
          alu_r[k]      <= alu_r[k-1];
          data_r[k]     <= data_r[k-1];
          wbdata_r[k]   <= wbdata_r[k-1];
          des_r[k]      <= des_r[k-1];
        end else begin
          memtoreg_r[k] <= memtoreg_r[k];
        end
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid     = valid_r[DEPTH-1];
  assign out_MemtoReg  = memtoreg_r[DEPTH-1];
  assign out_RegWrite  = valid_r[DEPTH-1] & regwrite_r[DEPTH-1];
  assign out_ALUResult = alu_r[DEPTH-1];
  assign out_data      = data_r[DEPTH-1];
  assign out_wbdata    = wbdata_r[DEPTH-1];
  assign out_des       = des_r[DEPTH-1];

  // Forwarding lookup: scan oldest to youngest so the youngest match wins; r0 never hits.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = {DATA_W{1'b0}};
    fwd_data_b = {DATA_W{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_r[k] && regwrite_r[k] && (des_r[k] == src_a) && (src_a != {REG_AW{1'b0}})) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = wbdata_r[k];
      end else begin
        fwd_hit_a  = fwd_hit_a;
      end
      if (valid_r[k] && regwrite_r[k] && (des_r[k] == src_b) && (src_b != {REG_AW{1'b0}})) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = wbdata_r[k];
      end else begin
        fwd_hit_b  = fwd_hit_b;
      end
    end
  end

`ifdef MEMWB_STAT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] bubble_cnt_r;
  logic        stall_inc_s;
  logic        bubble_inc_s;

  assign stall_inc_s  = phase_s & stall & ~flush;
  assign bubble_inc_s = adv_s & ~in_valid;

  // Saturating statistics counters; a clear request beats an increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_r  <= 16'h0000;
      bubble_cnt_r <= 16'h0000;
    end else if (stat_clear) begin
      stall_cnt_r  <= 16'h0000;
      bubble_cnt_r <= 16'h0000;
    end else begin
      if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bubble_inc_s && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'h0001;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
`else
  logic unused_clr_s;
  assign unused_clr_s = stat_clear;
  assign stall_cnt    = 16'h0000;
  assign bubble_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_memwb_stage_pipe.sv
// Bench for memwb_stage_pipe: one DEPTH=1 and one DEPTH=3 instance share the
// stimulus; a slot-array model of each pipe is checked every negative edge,
// and directed steps pin the model with hand-computed literals.
module tb_memwb_stage_pipe;

  localparam logic [4:0] PH = 5'b01000;
  localparam logic [4:0] NP = 5'b00001;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  phasecounter;
  logic        stall, flush, in_valid, in_MemtoReg, in_RegWrite, stat_clear;
  logic [15:0] in_ALUResult, in_data;
  logic [2:0]  in_des, src_a, src_b;

  logic        ov [2];
  logic        om [2];
  logic        ow [2];
  logic [15:0] oalu [2];
  logic [15:0] odat [2];
  logic [15:0] owb [2];
  logic [2:0]  odes [2];
  logic        fha [2];
  logic        fhb [2];
  logic [15:0] fda [2];
  logic [15:0] fdb [2];
  logic [15:0] scnt [2];
  logic [15:0] bcnt [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  memwb_stage_pipe #(.DEPTH(1)) u_d1 (
    .clock(clock), .reset(reset), .phasecounter(phasecounter), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
    .in_ALUResult(in_ALUResult), .in_data(in_data), .in_des(in_des),
    .src_a(src_a), .src_b(src_b), .stat_clear(stat_clear),
    .out_valid(ov[0]), .out_MemtoReg(om[0]), .out_RegWrite(ow[0]),
    .out_ALUResult(oalu[0]), .out_data(odat[0]), .out_wbdata(owb[0]), .out_des(odes[0]),
    .fwd_hit_a(fha[0]), .fwd_hit_b(fhb[0]), .fwd_data_a(fda[0]), .fwd_data_b(fdb[0]),
    .stall_cnt(scnt[0]), .bubble_cnt(bcnt[0]));

  memwb_stage_pipe #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .phasecounter(phasecounter), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite),
    .in_ALUResult(in_ALUResult), .in_data(in_data), .in_des(in_des),
    .src_a(src_a), .src_b(src_b), .stat_clear(stat_clear),
    .out_valid(ov[1]), .out_MemtoReg(om[1]), .out_RegWrite(ow[1]),
    .out_ALUResult(oalu[1]), .out_data(odat[1]), .out_wbdata(owb[1]), .out_des(odes[1]),
    .fwd_hit_a(fha[1]), .fwd_hit_b(fhb[1]), .fwd_data_a(fda[1]), .fwd_data_b(fdb[1]),
    .stall_cnt(scnt[1]), .bubble_cnt(bcnt[1]));

  // Model: each pipe is a row of instruction slots, slot 0 youngest.
  typedef struct packed {
    logic        v;
    logic        m;
    logic        w;
    logic [15:0] alu;
    logic [15:0] dat;
    logic [15:0] wb;
    logic [2:0]  des;
  } slot_t;

  slot_t mdl [2][4];
  int    dep [2] = '{1, 3};
  int    m_stall;
  int    m_bubble;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        mdl[i][k] = '0;
    m_stall  = 0;
    m_bubble = 0;
  endtask

  // What the pipe must hold after an edge, from the operation rules.
  task automatic model_edge();
    logic ph;
    ph = phasecounter[3];
    if (reset) begin
      model_clear();
    end else begin
      if (ph && flush) begin
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < 4; k++)
            mdl[i][k].v = 1'b0;
      end else if (ph && !stall) begin
        for (int i = 0; i < 2; i++) begin
          for (int k = dep[i] - 1; k >= 1; k--) begin
            if (mdl[i][k-1].v) mdl[i][k] = mdl[i][k-1];
            else mdl[i][k].v = 1'b0;
          end
          if (in_valid)
            mdl[i][0] = '{1'b1, in_MemtoReg, in_RegWrite, in_ALUResult, in_data,
                          (in_MemtoReg ? in_data : in_ALUResult), in_des};
          else
            mdl[i][0].v = 1'b0;
        end
      end
      if (stat_clear) begin
        m_stall  = 0;
        m_bubble = 0;
      end else begin
        if (ph && stall && !flush && m_stall < 65535) m_stall++;
        if (ph && !stall && !flush && !in_valid && m_bubble < 65535) m_bubble++;
      end
    end
  endtask

  function automatic logic [16:0] model_fwd(int i, logic [2:0] src);
    for (int k = 0; k < dep[i]; k++)
      if (src != 3'd0 && mdl[i][k].v && mdl[i][k].w && mdl[i][k].des == src)
        return {1'b1, mdl[i][k].wb};
    return 17'h0;
  endfunction

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        slot_t last;
        logic [16:0] fa, fb;
        int es, eb;
        last = mdl[i][dep[i]-1];
        fa = model_fwd(i, src_a);
        fb = model_fwd(i, src_b);
`ifdef MEMWB_STAT_EN
        es = m_stall;
        eb = m_bubble;
`else
        es = 0;
        eb = 0;
`endif
        check($sformatf("d%0d valid", dep[i]), {31'd0, ov[i]}, {31'd0, last.v});
        check($sformatf("d%0d memtoreg", dep[i]), {31'd0, om[i]}, {31'd0, last.m});
        check($sformatf("d%0d regwrite", dep[i]), {31'd0, ow[i]}, {31'd0, last.v & last.w});
        check($sformatf("d%0d alu", dep[i]), {16'd0, oalu[i]}, {16'd0, last.alu});
        check($sformatf("d%0d data", dep[i]), {16'd0, odat[i]}, {16'd0, last.dat});
        check($sformatf("d%0d wbdata", dep[i]), {16'd0, owb[i]}, {16'd0, last.wb});
        check($sformatf("d%0d des", dep[i]), {29'd0, odes[i]}, {29'd0, last.des});
        check($sformatf("d%0d fwd_a", dep[i]), {15'd0, fha[i], fda[i]}, {15'd0, fa});
        check($sformatf("d%0d fwd_b", dep[i]), {15'd0, fhb[i], fdb[i]}, {15'd0, fb});
        check($sformatf("d%0d stall_cnt", dep[i]), {16'd0, scnt[i]}, es);
        check($sformatf("d%0d bubble_cnt", dep[i]), {16'd0, bcnt[i]}, eb);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic v, input logic m, input logic w,
                        input logic [15:0] alu, input logic [15:0] dat, input logic [2:0] des);
    in_valid = v; in_MemtoReg = m; in_RegWrite = w;
    in_ALUResult = alu; in_data = dat; in_des = des;
  endtask

  logic [15:0] exp_sat;
  logic [15:0] exp_four;

  initial begin
    reset = 1'b1; phasecounter = NP; stall = 1'b0; flush = 1'b0; stat_clear = 1'b0;
    src_a = 3'd0; src_b = 3'd0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    model_clear();
`ifdef MEMWB_STAT_EN
    exp_sat  = 16'hFFFF;
    exp_four = 16'd4;
`else
    exp_sat  = 16'h0000;
    exp_four = 16'h0000;
`endif
    tick(); tick();
    reset = 1'b0;
    check("reset wbdata", {16'd0, owb[1]}, 32'h0);
    check("reset valid", {31'd0, ov[0]}, 32'h0);

    // Legacy single-stage capture.
    phasecounter = PH;
    set_in(1'b1, 1'b0, 1'b1, 16'h1234, 16'hAAAA, 3'd3);
    tick();
    check("d1 first valid", {31'd0, ov[0]}, 32'h1);
    check("d1 first wbdata", {16'd0, owb[0]}, 32'h1234);
    check("d1 first regwrite", {31'd0, ow[0]}, 32'h1);
    check("d3 not yet out", {31'd0, ov[1]}, 32'h0);

    // Three more instructions back to back; all target r3.
    set_in(1'b1, 1'b0, 1'b1, 16'h1111, 16'h0F0F, 3'd3); tick();
    set_in(1'b1, 1'b1, 1'b1, 16'h0BAD, 16'h2222, 3'd3); tick();
    check("d3 latency wbdata", {16'd0, owb[1]}, 32'h1234);
    set_in(1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 3'd3); tick();
    src_a = 3'd3; src_b = 3'd0;
    #1;
    check("d3 out second", {16'd0, owb[1]}, 32'h1111);
    check("d3 youngest fwd hit", {31'd0, fha[1]}, 32'h1);
    check("d3 youngest fwd data", {16'd0, fda[1]}, 32'h3333);
    check("d3 r0 no hit", {31'd0, fhb[1]}, 32'h0);

    // Bubble enters; memory-data instruction reaches the output.
    set_in(1'b0, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 3'd6); tick();
    check("d3 memtoreg wbdata", {16'd0, owb[1]}, 32'h2222);
    check("d1 bubble valid", {31'd0, ov[0]}, 32'h0);

    // Stall for four phase cycles: everything frozen.
    stall = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 16'h7777, 16'h8888, 3'd5);
    for (int n = 0; n < 4; n++) tick();
    check("stall frozen", {16'd0, owb[1]}, 32'h2222);
    check("stall_cnt four", {16'd0, scnt[1]}, {16'd0, exp_four});

    // Flush outside the phase is ignored.
    stall = 1'b0; flush = 1'b1; phasecounter = NP;
    tick();
    check("offphase flush ignored", {31'd0, ov[1]}, 32'h1);

    // Stall and flush together in phase: flush wins, payload stays.
    stall = 1'b1; phasecounter = PH;
    tick();
    check("flush valid", {31'd0, ov[1]}, 32'h0);
    check("flush regwrite", {31'd0, ow[1]}, 32'h0);
    check("flush fwd", {31'd0, fha[1]}, 32'h0);
    check("flush payload", {16'd0, owb[1]}, 32'h2222);
    stall = 1'b0; flush = 1'b0;

    // Writing r0 never forwards.
    src_a = 3'd0;
    set_in(1'b1, 1'b0, 1'b1, 16'h5555, 16'h0000, 3'd0); tick();
    check("r0 write no hit", {31'd0, fha[0]}, 32'h0);
    check("r0 write out", {16'd0, owb[0]}, 32'h5555);

    // Mixed directed traffic with alternating phase.
    for (int n = 0; n < 16; n++) begin
      logic [15:0] a, d;
      a = 16'h0100 * n[15:0] + 16'h0011;
      d = 16'hF000 - 16'h0101 * n[15:0];
      phasecounter = (n % 3 == 2) ? NP : PH;
      stall = (n % 5 == 4);
      set_in(n % 4 != 1, n[0], n % 3 != 0, a, d, n[2:0]);
      src_a = n[2:0] + 3'd1;
      src_b = n[2:0];
      tick();
    end
    stall = 1'b0;

    // Asynchronous reset between edges.
    @(posedge clock);
    model_edge();
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    check("async reset valid", {31'd0, ov[1]}, 32'h0);
    check("async reset wbdata", {16'd0, owb[0]}, 32'h0);
    check("async reset alu", {16'd0, oalu[1]}, 32'h0);
    check("async reset stall_cnt", {16'd0, scnt[0]}, 32'h0);
    #3;
    reset = 1'b0;

    // Bubble flood saturates the bubble counter, then clear.
    phasecounter = PH;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
    for (int n = 0; n < 65540; n++) tick();
    check("bubble saturate", {16'd0, bcnt[0]}, {16'd0, exp_sat});
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("stat clear", {16'd0, bcnt[1]}, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
